// File: rtl/dtm_pkg.sv
// rtl/dtm_pkg.sv - shared types and constants for the JTAG debug transport module
package dtm_pkg;

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_e;

    localparam logic [4:0] IR_IDCODE  = 5'h01;
    localparam logic [4:0] IR_DTMCS   = 5'h10;
    localparam logic [4:0] IR_DMI     = 5'h11;
    localparam logic [4:0] IR_CAPTURE = 5'b00001;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam logic [1:0] DMI_STAT_OK   = 2'd0;
    localparam logic [1:0] DMI_STAT_BUSY = 2'd3;

    localparam int DTMCS_DMIRESET_BIT  = 16;
    localparam int DTMCS_HARDRESET_BIT = 17;

    typedef struct packed {
        logic [13:0] zero_hi;
        logic        dmihardreset;
        logic        dmireset;
        logic        zero_15;
        logic [2:0]  idle;
        logic [1:0]  dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

    typedef struct packed {
        logic [6:0]  address;
        logic [31:0] data;
        logic [1:0]  op;
    } dmi_scan_t;

endpackage

// File: rtl/dmi_jtag_dtm_if.sv
// rtl/dmi_jtag_dtm_if.sv - DMI trivial bus between the DTM (master) and the DM (slave)
interface dmi_jtag_dtm_if;
    logic        dmi_start;
    logic        dmi_finish;
    logic [1:0]  dmi_op;
    logic [31:0] dmi_data_o;
    logic [31:0] dmi_data_i;
    logic [6:0]  dmi_address;

    modport master (
        output dmi_start, dmi_op, dmi_data_o, dmi_address,
        input  dmi_finish, dmi_data_i
    );

    modport slave (
        input  dmi_start, dmi_op, dmi_data_o, dmi_address,
        output dmi_finish, dmi_data_i
    );
endinterface

// File: rtl/jtag_sync.sv
// rtl/jtag_sync.sv - oversampling synchronizers for tck/tms/tdi with tck edge strobes
module jtag_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    output logic tck_rise,
    output logic tck_fall,
    output logic tms_s,
    output logic tdi_s
);
    logic [2:0] tck_q;
    logic [1:0] tms_q;
    logic [1:0] tdi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_q <= '0;
            tms_q <= '0;
            tdi_q <= '0;
        end else begin
            tck_q <= {tck_q[1:0], tck};
            tms_q <= {tms_q[0], tms};
            tdi_q <= {tdi_q[0], tdi};
        end
    end

    // tck_q[1] is the synchronized level, tck_q[2] its one-clk history
    assign tck_rise = tck_q[1] & ~tck_q[2];
    assign tck_fall = ~tck_q[1] & tck_q[2];
    assign tms_s    = tms_q[1];
    assign tdi_s    = tdi_q[1];
endmodule

// File: rtl/dmi_jtag_dtm.sv
// rtl/dmi_jtag_dtm.sv - JTAG TAP with IDCODE/DTMCS/DMI/BYPASS driving the DMI request bus
module dmi_jtag_dtm
    import dtm_pkg::*;
#(
    parameter logic [31:0] IDCODE    = 32'h1BEE_F001,
    parameter logic [2:0]  IDLE_HINT = 3'd1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    output logic tdo,
    dmi_jtag_dtm_if.master dmi
);
    logic tck_rise, tck_fall, tms_s, tdi_s;

    jtag_sync u_sync (
        .clk(clk), .rst_n(rst_n), .tck(tck), .tms(tms), .tdi(tdi),
        .tck_rise(tck_rise), .tck_fall(tck_fall), .tms_s(tms_s), .tdi_s(tdi_s)
    );

    tap_state_e state_q, state_d;
    logic capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        state_q <= TLR;
        else if (tck_rise) state_q <= state_d;
    end

    always_comb begin
        state_d = TLR;
        case (state_q)
            TLR:      state_d = tms_s ? TLR      : RTI;
            RTI:      state_d = tms_s ? SEL_DR   : RTI;
            SEL_DR:   state_d = tms_s ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = tms_s ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_d = tms_s ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_d = tms_s ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = tms_s ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_d = tms_s ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_d = tms_s ? SEL_DR   : RTI;
            SEL_IR:   state_d = tms_s ? TLR      : CAP_IR;
            CAP_IR:   state_d = tms_s ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_d = tms_s ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_d = tms_s ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = tms_s ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_d = tms_s ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_d = tms_s ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    // Capture/shift act on the rise that leaves the state; updates fire on the fall inside Update
    always_comb begin
        capture_dr = tck_rise && (state_q == CAP_DR);
        shift_dr   = tck_rise && (state_q == SHIFT_DR);
        update_dr  = tck_fall && (state_q == UPD_DR);
        capture_ir = tck_rise && (state_q == CAP_IR);
        shift_ir   = tck_rise && (state_q == SHIFT_IR);
        update_ir  = tck_fall && (state_q == UPD_IR);
    end

    logic [4:0]  ir_q;
    logic [40:0] sr_q, sr_shift;
    logic        busy_q, err_q, hard_pend_q;
    logic [31:0] result_q;
    dtmcs_t      dtmcs_cap;
    dmi_scan_t   dmi_cap, upd_scan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                ir_q <= IR_IDCODE;
        else if (state_q == TLR)   ir_q <= IR_IDCODE;
        else if (update_ir)        ir_q <= sr_q[4:0];
    end

    // One shift register serves IR and every DR; tdi enters at the selected length's MSB
    always_comb begin
        sr_shift = {40'b0, tdi_s};
        if (state_q == SHIFT_IR) begin
            sr_shift = {36'b0, tdi_s, sr_q[4:1]};
        end else begin
            case (ir_q)
                IR_IDCODE, IR_DTMCS: sr_shift = {9'b0, tdi_s, sr_q[31:1]};
                IR_DMI:              sr_shift = {tdi_s, sr_q[40:1]};
                default:             sr_shift = {40'b0, tdi_s};
            endcase
        end
    end

    always_comb begin
        dtmcs_cap              = '0;
        dtmcs_cap.version      = 4'd1;
        dtmcs_cap.abits        = 6'd7;
        dtmcs_cap.dmistat      = err_q ? DMI_STAT_BUSY : DMI_STAT_OK;
        dtmcs_cap.idle         = IDLE_HINT;
        dmi_cap.address        = dmi.dmi_address;
        dmi_cap.data           = result_q;
        dmi_cap.op             = (busy_q || err_q) ? DMI_STAT_BUSY : DMI_STAT_OK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (capture_ir) begin
            sr_q <= {36'b0, IR_CAPTURE};
        end else if (capture_dr) begin
            case (ir_q)
                IR_IDCODE: sr_q <= {9'b0, IDCODE};
                IR_DTMCS:  sr_q <= {9'b0, dtmcs_cap};
                IR_DMI:    sr_q <= dmi_cap;
                default:   sr_q <= '0;
            endcase
        end else if (shift_dr || shift_ir) begin
            sr_q <= sr_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        tdo <= 1'b0;
        else if (tck_fall) tdo <= sr_q[0];
    end

    assign upd_scan = dmi_scan_t'(sr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmi.dmi_start   <= 1'b0;
            dmi.dmi_op      <= DMI_OP_NOP;
            dmi.dmi_address <= '0;
            dmi.dmi_data_o  <= '0;
            busy_q          <= 1'b0;
            err_q           <= 1'b0;
            hard_pend_q     <= 1'b0;
            result_q        <= '0;
        end else begin
            dmi.dmi_start <= 1'b0;
            if (dmi.dmi_finish && busy_q) begin
                busy_q      <= 1'b0;
                hard_pend_q <= 1'b0;
                if (dmi.dmi_op == DMI_OP_READ && !hard_pend_q) result_q <= dmi.dmi_data_i;
            end
            if (capture_dr && ir_q == IR_DMI && busy_q && !hard_pend_q) err_q <= 1'b1;
            if (update_dr && ir_q == IR_DTMCS) begin
                if (sr_q[DTMCS_DMIRESET_BIT] || sr_q[DTMCS_HARDRESET_BIT]) err_q <= 1'b0;
                // A hard reset abandons the in-flight result but still waits for its finish
                if (sr_q[DTMCS_HARDRESET_BIT] && busy_q && !dmi.dmi_finish) hard_pend_q <= 1'b1;
            end
            if (update_dr && ir_q == IR_DMI && !err_q) begin
                if (busy_q) begin
                    if (!hard_pend_q) err_q <= 1'b1;
                end else if (upd_scan.op == DMI_OP_READ || upd_scan.op == DMI_OP_WRITE) begin
                    dmi.dmi_start   <= 1'b1;
                    dmi.dmi_op      <= upd_scan.op;
                    dmi.dmi_address <= upd_scan.address;
                    dmi.dmi_data_o  <= upd_scan.data;
                    busy_q          <= 1'b1;
                end
            end
        end
    end
endmodule
